// File: rtl/hack_pkg.sv
// Shared Hack CPU constants: datapath width, reset PC and the C-instruction jump-field encodings.
package hack_pkg;

  localparam int          HACK_WIDTH       = 16;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // Jump field j1 j2 j3 = {lt, eq, gt}
  localparam logic [2:0] JNULL = 3'b000;
  localparam logic [2:0] JGT   = 3'b001;
  localparam logic [2:0] JEQ   = 3'b010;
  localparam logic [2:0] JGE   = 3'b011;
  localparam logic [2:0] JLT   = 3'b100;
  localparam logic [2:0] JNE   = 3'b101;
  localparam logic [2:0] JLE   = 3'b110;
  localparam logic [2:0] JMP   = 3'b111;

endpackage

// File: rtl/or8way.sv
// Eight-input OR gate, the leaf of the Hack zero-detect tree.
module or8way (
  input  logic [7:0] in,
  output logic       out
);

  assign out = |in;

endmodule

// File: rtl/zero_detect16.sv
// 16-bit zero detector built from two or8way halves; zr is high when every bit is 0.
module zero_detect16 (
  input  logic [15:0] data,
  output logic        zr
);

  logic any_lo;
  logic any_hi;

  or8way u_or_lo (.in(data[7:0]),  .out(any_lo));
  or8way u_or_hi (.in(data[15:8]), .out(any_hi));

  assign zr = ~(any_lo | any_hi);

endmodule

// File: rtl/hack_pc_jump.sv
// Hack CPU program-counter stage: zr/ng flags, jump evaluation and PC update.
// Optional sticky jump-to-self halt is enabled by defining PC_HALT_EN.
module hack_pc_jump
  import hack_pkg::*;
#(
  parameter int               WIDTH    = HACK_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             is_c_inst,
  input  logic [2:0]       jmp,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] pc,
  output logic             zr,
  output logic             ng,
  output logic             jump_taken,
  output logic             halted
);

  logic zr_c;
  logic ng_c;
  logic take;

  generate
    if (WIDTH == 16) begin : g_zd16
      zero_detect16 u_zero_detect (.data(alu_out), .zr(zr_c));
    end else begin : g_zd_generic
      assign zr_c = ~|alu_out;
    end
  endgenerate

  assign ng_c = alu_out[WIDTH-1];
  assign take = is_c_inst & ((jmp[2] & ng_c) | (jmp[1] & zr_c) | (jmp[0] & ~ng_c & ~zr_c));

`ifdef PC_HALT_EN
  // Loading the PC with its own value is the Hack idiom for "program finished".
  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (en && take && (a_reg == pc)) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      zr         <= 1'b0;
      ng         <= 1'b0;
      jump_taken <= 1'b0;
    end else begin
      jump_taken <= 1'b0;
      if (en && !halted) begin
        zr <= zr_c;
        ng <= ng_c;
        if (take) begin
          pc         <= a_reg;
          jump_taken <= 1'b1;
        end else begin
          pc <= pc + 1'b1;
        end
      end
    end
  end

endmodule
